// File: rtl/addsub_serial.sv
// Digit-serial signed add/subtract: DIGIT bits per clock through a ripple digit adder and a carry register.
// Optional clamp-on-overflow output is built only when ADDSUB_SATURATE_EN is defined.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for an operand pair
//   RUN   | one digit added per edge, cnt selects the digit
//   DONE  | out_valid=1, result held until out_ready
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic             ci,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             co,
  output logic             of
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic             op_q;
  logic             carry;

  logic [DIGIT-1:0] xd;
  logic [DIGIT-1:0] yd;
  logic [DIGIT:0]   sum;
  logic             msb_cin;
  logic             ovf;
  logic [WIDTH-1:0] r_next;
  logic             last;

  // y_q already holds ~y for subtract, so the digit adder never needs to know op.
  always_comb begin
    xd      = x_q[cnt*DIGIT +: DIGIT];
    yd      = y_q[cnt*DIGIT +: DIGIT];
    sum     = {1'b0, xd} + {1'b0, yd} + {{DIGIT{1'b0}}, carry};
    // Carry into the digit's top bit recovered from its sum bit; with DIGIT=1 this is the carry register.
    msb_cin = xd[DIGIT-1] ^ yd[DIGIT-1] ^ sum[DIGIT-1];
    ovf     = msb_cin ^ sum[DIGIT];
    r_next  = r;
    r_next[cnt*DIGIT +: DIGIT] = sum[DIGIT-1:0];
    last    = (cnt == CNT_LAST);
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      op_q  <= 1'b0;
      carry <= 1'b0;
      r     <= '0;
      co    <= 1'b0;
      of    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q   <= x;
            y_q   <= op ? ~y : y;
            op_q  <= op;
            carry <= ci ^ op;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= sum[DIGIT];
          if (last) begin
            cnt   <= '0;
            co    <= sum[DIGIT] ^ op_q;
            of    <= ovf;
            state <= DONE;
`ifdef ADDSUB_SATURATE_EN
            // Both operands share a sign on overflow, so x's sign picks the clamp direction.
            if (ovf)
              r <= x_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            else
              r <= r_next;
`else
            r <= r_next;
`endif
          end else begin
            r   <= r_next;
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: DIGIT=1, 4 and 16 instances share one stimulus stream
// and are compared against an integer-arithmetic reference model.
module tb_addsub_serial;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         op = 1'b0;
  logic         ci = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;

  logic [2:0]   in_rdy;
  logic [2:0]   out_vld;
  logic [2:0]   co_v;
  logic [2:0]   of_v;
  logic [W-1:0] r_v [3];

  int checks = 0;
  int errors = 0;

  logic [W-1:0] got_r;
  logic         got_co;
  logic         got_of;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[0]), .op(op), .ci(ci),
    .x(x), .y(y), .out_valid(out_vld[0]), .out_ready(out_ready), .r(r_v[0]), .co(co_v[0]), .of(of_v[0]));
  addsub_serial #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[1]), .op(op), .ci(ci),
    .x(x), .y(y), .out_valid(out_vld[1]), .out_ready(out_ready), .r(r_v[1]), .co(co_v[1]), .of(of_v[1]));
  addsub_serial #(.WIDTH(W), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[2]), .op(op), .ci(ci),
    .x(x), .y(y), .out_valid(out_vld[2]), .out_ready(out_ready), .r(r_v[2]), .co(co_v[2]), .of(of_v[2]));

  function automatic int digit_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 16;
  endfunction

  // Reference: returns {of, co, r} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    int ua, ub, sa, sb, u, s;
    logic [W-1:0] rr;
    logic cc, oo;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!o) begin
      u  = ua + ub + int'(c);
      s  = sa + sb + int'(c);
      cc = (u > 65535);
    end else begin
      u  = ua - ub - int'(c);
      s  = sa - sb - int'(c);
      cc = (u < 0);
    end
    rr = u[W-1:0];
    oo = (s > 32767) || (s < -32768);
`ifdef ADDSUB_SATURATE_EN
    if (oo) rr = (s > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {oo, cc, rr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (in_rdy !== 3'b111 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("all_idle", 32'(in_rdy), 32'h7);
  endtask

  // Issues one op to all three instances and checks latency and result of each.
  task automatic run_all(input logic o, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W+1:0] e;
    logic [2:0]   seen;
    wait_idle();
    op = o; x = a; y = b; ci = c; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    x = W'($urandom);
    y = W'($urandom);
    op = 1'($urandom);
    ci = 1'($urandom);
    e = model(o, a, b, c);
    seen = '0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (out_vld[i] && !seen[i]) begin
          seen[i] = 1'b1;
          chk($sformatf("latency_d%0d", digit_of(i)), 32'(cyc), 32'(W / digit_of(i)));
          chk($sformatf("r_d%0d", digit_of(i)), 32'(r_v[i]), 32'(e[W-1:0]));
          chk($sformatf("co_d%0d", digit_of(i)), 32'(co_v[i]), 32'(e[W]));
          chk($sformatf("of_d%0d", digit_of(i)), 32'(of_v[i]), 32'(e[W+1]));
          if (i == 1) begin
            got_r  = r_v[i];
            got_co = co_v[i];
            got_of = of_v[i];
          end
        end
      end
    end
    chk("result_seen", 32'(seen), 32'h7);
  endtask

  initial begin
    logic [W+1:0] e;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_rdy), 32'h7);
    chk("rst_out_valid", 32'(out_vld), 32'h0);
    chk("rst_co", 32'(co_v), 32'h0);
    chk("rst_of", 32'(of_v), 32'h0);
    for (int i = 0; i < 3; i++) chk($sformatf("rst_r_d%0d", digit_of(i)), 32'(r_v[i]), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors with spec-given results
    run_all(1'b0, 16'h1234, 16'h0FFF, 1'b0);
    chk("t1_r", 32'(got_r), 32'h2233);
    chk("t1_co", 32'(got_co), 32'h0);
    chk("t1_of", 32'(got_of), 32'h0);
    run_all(1'b1, 16'h0000, 16'h0001, 1'b0);
    chk("t2a_r", 32'(got_r), 32'hFFFF);
    chk("t2a_co", 32'(got_co), 32'h1);
    run_all(1'b1, 16'h0005, 16'h0003, 1'b1);
    chk("t2b_r", 32'(got_r), 32'h0001);
    chk("t2b_co", 32'(got_co), 32'h0);
    run_all(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    chk("t3a_of", 32'(got_of), 32'h1);
`ifdef ADDSUB_SATURATE_EN
    chk("t3a_r", 32'(got_r), 32'h7FFF);
`else
    chk("t3a_r", 32'(got_r), 32'h8000);
`endif
    run_all(1'b1, 16'h8000, 16'h0001, 1'b0);
    chk("t3b_of", 32'(got_of), 32'h1);
`ifdef ADDSUB_SATURATE_EN
    chk("t3b_r", 32'(got_r), 32'h8000);
`else
    chk("t3b_r", 32'(got_r), 32'h7FFF);
`endif
    run_all(1'b0, 16'hFFFF, 16'h0000, 1'b1);
    run_all(1'b0, 16'h8000, 16'h8000, 1'b0);
    run_all(1'b1, 16'h7FFF, 16'hFFFF, 1'b1);

    // Back-pressure on the DIGIT=4 instance with a pending operand pair
    wait_idle();
    out_ready = 1'b0;
    op = 1'b1; x = 16'h4321; y = 16'h1111; ci = 1'b0; in_valid = 1'b1;
    e = model(1'b1, 16'h4321, 16'h1111, 1'b0);
    @(posedge clk);
    @(negedge clk);
    op = 1'b0; x = 16'h7FFF; y = 16'h0001;
    n = 0;
    while (!out_vld[1] && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 32'(out_vld[1]), 32'h1);
    for (int k = 0; k < 10; k++) begin
      chk("bp_r", 32'(r_v[1]), 32'(e[W-1:0]));
      chk("bp_co", 32'(co_v[1]), 32'(e[W]));
      chk("bp_of", 32'(of_v[1]), 32'(e[W+1]));
      chk("bp_in_ready", 32'(in_rdy[1]), 32'h0);
      chk("bp_hold_valid", 32'(out_vld[1]), 32'h1);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_rel_in_ready", 32'(in_rdy[1]), 32'h1);
    chk("bp_rel_out_valid", 32'(out_vld[1]), 32'h0);

    // Reset after two digits of the DIGIT=4 instance
    wait_idle();
    op = 1'b0; x = 16'h5555; y = 16'h3333; ci = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_rdy), 32'h7);
    chk("mid_rst_out_valid", 32'(out_vld), 32'h0);
    chk("mid_rst_r", 32'(r_v[1]), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    run_all(1'b0, 16'h1111, 16'h2222, 1'b1);
    chk("post_rst_r", 32'(got_r), 32'h3334);

    // Random sweep across all three digit widths
    for (int t = 0; t < 40; t++)
      run_all(1'($urandom), W'($urandom), W'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
